// File: rtl/bsg_chip_pkg.sv
// ============================================================================
//  Module   : bsg_chip_pkg
//  Brief    : Chip-link constants (ct link flit layout) and the wormhole
//             arbiter state encoding, shared by the arbiter and its picker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bsg_chip_pkg;

  // The length field sits directly above the mem_noc cord field in a header.
  localparam int c_MEM_NOC_CORD_WIDTH = 8;
  localparam int c_CT_FLIT_WIDTH      = 32;
  localparam int c_CT_LEN_WIDTH       = 4;
  localparam int c_CT_LEN_OFFSET      = c_MEM_NOC_CORD_WIDTH;

  typedef enum logic [0:0] {
    eIdle = 1'b0,
    eBusy = 1'b1
  } arb_state_e;

  // Round-robin successor with an explicit wrap, so non power-of-two
  // requester counts never land on an unused index.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_chip_rr_pick.sv
// ============================================================================
//  Module   : bsg_chip_rr_pick
//  Brief    : Combinational round-robin picker. Scans the request vector
//             starting at i_start, wrapping, and returns the first hit as a
//             one-hot grant plus its encoded index. All zero when no request.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_chip_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_start,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx
);

  logic             w_found;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;

  // Walk the ring from the start pointer; the first requester seen wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_start} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_chip_link_wormhole_arbiter.sv
// ============================================================================
//  Module   : bsg_chip_link_wormhole_arbiter
//  Brief    : Packet-granular round-robin arbiter sharing one ready_and
//             wormhole link. Grants on a header, locks until the tail flit
//             has transferred, advances the pointer only on completion.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_chip_link_wormhole_arbiter
  import bsg_chip_pkg::*;
#(
  parameter int num_in_p     = 3,
  parameter int flit_width_p = c_CT_FLIT_WIDTH,
  parameter int len_width_p  = c_CT_LEN_WIDTH,
  parameter int len_offset_p = c_CT_LEN_OFFSET
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_in_p-1:0]              v_i,
  input  logic [num_in_p*flit_width_p-1:0] data_i,
  output logic [num_in_p-1:0]              ready_o,
  output logic                             v_o,
  output logic [flit_width_p-1:0]          data_o,
  input  logic                             ready_i,
  output logic [num_in_p-1:0]              grant_o,
  output logic                             busy_o
);

  localparam int         c_PTR_W   = $clog2(num_in_p);
  localparam logic [0:0] c_ST_IDLE = eIdle;
  localparam logic [0:0] c_ST_BUSY = eBusy;

  logic [0:0]             r_state;
  logic [c_PTR_W-1:0]     r_rr_ptr;
  logic [num_in_p-1:0]    r_gnt;
  logic [c_PTR_W-1:0]     r_gnt_idx;
  logic [len_width_p-1:0] r_cnt;

  logic                    w_busy;
  logic [num_in_p-1:0]     w_pick_grant;
  logic [c_PTR_W-1:0]      w_pick_idx;
  logic [num_in_p-1:0]     w_grant;
  logic                    w_v;
  logic [flit_width_p-1:0] w_data;
  logic                    w_xfer;
  logic [len_width_p-1:0]  w_len;

  bsg_chip_rr_pick #(
    .NUM_REQ (num_in_p),
    .PTR_W   (c_PTR_W)
  ) u_pick (
    .i_req   (v_i),
    .i_start (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  assign w_busy  = (r_state == c_ST_BUSY);
  assign w_grant = w_busy ? r_gnt : w_pick_grant;
  // While locked only the owner's valid matters, so a bubble stalls the link.
  assign w_v     = w_busy ? |(v_i & r_gnt) : |v_i;

  // One-hot AND-OR output mux built as an OR chain over masked flits.
  logic [flit_width_p-1:0] w_or [num_in_p+1];
  assign w_or[0] = '0;
  for (genvar g = 0; g < num_in_p; g++) begin : g_mux
    assign w_or[g+1] = w_or[g]
                     | (data_i[g*flit_width_p +: flit_width_p] & {flit_width_p{w_grant[g]}});
  end
  assign w_data = w_or[num_in_p];

  assign v_o     = ~reset_i & w_v;
  assign data_o  = w_data;
  assign grant_o = reset_i ? '0 : w_grant;
  assign ready_o = {num_in_p{ready_i & ~reset_i}} & w_grant;
  assign busy_o  = ~reset_i & w_busy;

  assign w_xfer = v_o & ready_i;
  assign w_len  = w_data[len_offset_p +: len_width_p];

  // Packet lock FSM: header opens a lock, counter runs down body flits.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= c_ST_IDLE;
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_cnt     <= '0;
    end else if (w_xfer) begin
      if (!w_busy) begin
        if (w_len == '0) begin
          r_rr_ptr <= c_PTR_W'(rr_next(int'(w_pick_idx), num_in_p));
        end else begin
          r_state   <= c_ST_BUSY;
          r_gnt     <= w_pick_grant;
          r_gnt_idx <= w_pick_idx;
          r_cnt     <= w_len;
        end
      end else if (r_cnt == len_width_p'(1)) begin
        r_state  <= c_ST_IDLE;
        r_rr_ptr <= c_PTR_W'(rr_next(int'(r_gnt_idx), num_in_p));
        r_cnt    <= '0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - len_width_p'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bsg_chip_link_wormhole_arbiter.sv
// ============================================================================
//  Module   : tb_bsg_chip_link_wormhole_arbiter
//  Brief    : Randomized self-checking bench. Each requester streams whole
//             packets; a packet-level reference model predicts grant, valid,
//             ready, busy and the forwarded flit every cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bsg_chip_link_wormhole_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int LW = 4;
  localparam int LO = 8;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ready_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           ready_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  always #5 clk = ~clk;

  bsg_chip_link_wormhole_arbiter #(
    .num_in_p     (N),
    .flit_width_p (W),
    .len_width_p  (LW),
    .len_offset_p (LO)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: the flit each requester currently offers and where it
  // is inside its packet (0 = header, plen = tail).
  logic [W-1:0] cur_flit [N];
  int           pos      [N];
  int           plen     [N];
  bit           zero_len_mode = 1'b0;
  int           valid_pct = 100;
  int           ready_pct = 100;

  // Reference model: who owns the link, flits left in the locked packet,
  // and which requester gets first look at the next arbitration.
  int m_owner;
  int m_rem;
  int m_ptr;

  task automatic new_packet(input int i);
    cur_flit[i] = $urandom;
    plen[i]     = zero_len_mode ? 0 : int'($urandom_range(0, 15));
    cur_flit[i][LO +: LW] = LW'(plen[i]);
    pos[i] = 0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rem   = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) new_packet(i);
  endtask

  task automatic cycle(input bit rst);
    logic [N-1:0] e_g;
    logic         e_v;
    logic         e_busy;
    int           w;
    bit           xfer;
    int           len;

    reset_i = rst;
    ready_i = ($urandom_range(0, 99) < ready_pct);
    for (int i = 0; i < N; i++) begin
      v_i[i] = ($urandom_range(0, 99) < valid_pct);
      data_i[i*W +: W] = cur_flit[i];
    end
    #1;

    e_g = '0; e_v = 1'b0; e_busy = 1'b0; w = -1;
    if (!rst) begin
      if (m_owner >= 0) begin
        w      = m_owner;
        e_v    = v_i[w];
        e_busy = 1'b1;
        e_g[w] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (w < 0 && v_i[j]) w = j;
        end
        if (w >= 0) begin
          e_g[w] = 1'b1;
          e_v    = 1'b1;
        end
      end
    end

    chk("grant_o", 64'(grant_o), 64'(e_g));
    chk("v_o",     64'(v_o),     64'(e_v));
    chk("busy_o",  64'(busy_o),  64'(e_busy));
    chk("ready_o", 64'(ready_o), 64'(ready_i ? e_g : '0));
    if (e_v) chk("data_o", 64'(data_o), 64'(cur_flit[w]));

    xfer = e_v && ready_i && !rst;

    @(posedge clk);
    #1;

    if (rst) begin
      model_reset();
    end else if (xfer) begin
      len = int'(cur_flit[w][LO +: LW]);
      if (m_owner < 0) begin
        if (len == 0) m_ptr = (w + 1) % N;
        else begin
          m_owner = w;
          m_rem   = len;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_owner = -1;
          m_ptr   = (w + 1) % N;
        end
      end
      if (pos[w] == plen[w]) new_packet(w);
      else begin
        pos[w]++;
        cur_flit[w] = $urandom;
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    ready_i = 1'b0;
    v_i     = '0;
    data_i  = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset with every requester shouting: outputs must stay quiet.
    for (int c = 0; c < 3; c++) cycle(1'b1);

    // All requesters valid, single-flit packets: strict 0,1,2 rotation.
    zero_len_mode = 1'b1;
    cycle(1'b1);
    for (int c = 0; c < 12; c++) cycle(1'b0);

    // Mixed packet lengths, bubbles, back-pressure and occasional reset.
    zero_len_mode = 1'b0;
    cycle(1'b1);
    for (int blk = 0; blk < 6; blk++) begin
      valid_pct = 40 + 12 * blk;
      ready_pct = 100 - 10 * blk;
      for (int c = 0; c < 500; c++) begin
        cycle($urandom_range(0, 399) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
